// File: rtl/eeprom_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_seq_pkg
// Description : State encoding and wait-counter sizing for the EEPROM burst
//               sequencer. Verify states exist only with EEPROM_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package eeprom_seq_pkg;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ISSUE     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] c_ST_TWR_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_FINISH    = 3'd4;
`ifdef EEPROM_VERIFY_EN
    localparam logic [2:0] c_ST_VFY_ISSUE = 3'd5;
    localparam logic [2:0] c_ST_VFY_WAIT  = 3'd6;
`endif

    // Divide by 1000 first so the product stays inside 32 bits at real clock rates.
    function automatic int twr_cycles(input int sys_freq, input int twr_us);
        return (sys_freq / 1000) * twr_us / 1000;
    endfunction

    function automatic int cnt_width(input int twr_cyc, input int timeout_cyc);
        int m;
        m = (twr_cyc > timeout_cyc) ? twr_cyc : timeout_cyc;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eeprom_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_wait_timer
// Description : Loadable down-counter; expired is high while the count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_wait_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/eeprom_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_burst_sequencer
// Description : Multi-byte read/write bursts over the single-byte i2c_eeprom
//               start/done handshake, with tWR wait and timeout. Define
//               EEPROM_VERIFY_EN to read back and compare every written byte.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_burst_sequencer
    import eeprom_seq_pkg::*;
#(
    parameter int SYS_FREQ    = 12_090_000,
    parameter int MAX_LEN     = 4,
    parameter int TWR_US      = 5000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_start,
    input  logic                   req_rw,
    input  logic [7:0]             req_addr,
    input  logic [2:0]             req_len,
    input  logic [8*MAX_LEN-1:0]   wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [8*MAX_LEN-1:0]   rd_data,
    output logic                   ee_start,
    output logic                   ee_rw,
    output logic [7:0]             ee_address,
    output logic [7:0]             ee_data_in,
    input  logic [7:0]             ee_data_out,
    input  logic                   ee_done
);

    localparam int                 c_TWR_CYC = twr_cycles(SYS_FREQ, TWR_US);
    localparam int                 c_CNT_W   = cnt_width(c_TWR_CYC, TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_TWR_LD  = c_CNT_W'(c_TWR_CYC);
    localparam logic [c_CNT_W-1:0] c_TMO_LD  = c_CNT_W'(TIMEOUT_CYC);
    localparam logic [2:0]         c_MAX_LEN = 3'(MAX_LEN);

    logic [2:0]           r_state;
    logic                 r_rw;
    logic                 r_ee_rw;
    logic [7:0]           r_addr;
    logic [2:0]           r_len;
    logic [2:0]           r_idx;
    logic [8*MAX_LEN-1:0] r_wr_data;
    logic [8*MAX_LEN-1:0] r_rd_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic [7:0]           w_cur_wr;
    logic                 w_more;
    logic                 w_len_bad;
    logic                 w_issue;
    logic                 w_tmr_load;
    logic [c_CNT_W-1:0]   w_tmr_value;
    logic                 w_expired;

    always_comb begin
        w_cur_wr = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_idx == 3'(i)) w_cur_wr = r_wr_data[8*i +: 8];
        end
    end

    assign w_more    = (r_idx + 3'd1) < r_len;
    assign w_len_bad = (req_len == 3'd0) || (req_len > c_MAX_LEN);

`ifdef EEPROM_VERIFY_EN
    assign w_issue = (r_state == c_ST_ISSUE) || (r_state == c_ST_VFY_ISSUE);
`else
    assign w_issue = (r_state == c_ST_ISSUE);
`endif

    // One timer serves both waits: timeout on every issue, tWR after a write ack.
    always_comb begin
        w_tmr_load  = w_issue;
        w_tmr_value = c_TMO_LD;
        if ((r_state == c_ST_WAIT_DONE) && ee_done && !r_rw) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = c_TWR_LD;
        end
    end

    eeprom_wait_timer #(
        .WIDTH (c_CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rw      <= 1'b0;
            r_ee_rw   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req_start) begin
                        r_rw      <= req_rw;
                        r_ee_rw   <= req_rw;
                        r_addr    <= req_addr;
                        r_len     <= req_len;
                        r_wr_data <= wr_data;
                        r_idx     <= '0;
                        r_rd_data <= '0;
                        r_busy    <= 1'b1;
                        r_error   <= w_len_bad;
                        r_state   <= w_len_bad ? c_ST_FINISH : c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: r_state <= c_ST_WAIT_DONE;
                c_ST_WAIT_DONE: begin
                    if (ee_done) begin
                        if (r_rw) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (r_idx == 3'(i)) r_rd_data[8*i +: 8] <= ee_data_out;
                            end
                            if (w_more) begin
                                r_idx   <= r_idx + 3'd1;
                                r_addr  <= r_addr + 8'd1;
                                r_state <= c_ST_ISSUE;
                            end else begin
                                r_state <= c_ST_FINISH;
                            end
                        end else begin
                            r_state <= c_ST_TWR_WAIT;
                        end
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= c_ST_FINISH;
                    end
                end
                c_ST_TWR_WAIT: begin
                    if (w_expired) begin
`ifdef EEPROM_VERIFY_EN
                        r_ee_rw <= 1'b1;
                        r_state <= c_ST_VFY_ISSUE;
`else
                        if (w_more) begin
                            r_idx   <= r_idx + 3'd1;
                            r_addr  <= r_addr + 8'd1;
                            r_state <= c_ST_ISSUE;
                        end else begin
                            r_state <= c_ST_FINISH;
                        end
`endif
                    end
                end
`ifdef EEPROM_VERIFY_EN
                c_ST_VFY_ISSUE: r_state <= c_ST_VFY_WAIT;
                c_ST_VFY_WAIT: begin
                    if (ee_done) begin
                        if (ee_data_out != w_cur_wr) begin
                            r_error <= 1'b1;
                            r_state <= c_ST_FINISH;
                        end else if (w_more) begin
                            r_ee_rw <= r_rw;
                            r_idx   <= r_idx + 3'd1;
                            r_addr  <= r_addr + 8'd1;
                            r_state <= c_ST_ISSUE;
                        end else begin
                            r_state <= c_ST_FINISH;
                        end
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_state <= c_ST_FINISH;
                    end
                end
`endif
                c_ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign rd_data    = r_rd_data;
    assign ee_start   = w_issue;
    assign ee_rw      = r_ee_rw;
    assign ee_address = r_addr;
    assign ee_data_in = w_cur_wr;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_burst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eeprom_burst_sequencer
// Description : Scoreboard bench for eeprom_burst_sequencer with a behavioural
//               single-byte EEPROM model. Honours EEPROM_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_burst_sequencer;

    localparam int c_MAX_LEN  = 4;
    localparam int c_SYS_FREQ = 1_000_000;
    localparam int c_TWR_US   = 20;
    localparam int c_TWR      = 20;   // 1000 * 20 / 1000
    localparam int c_TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_start = 1'b0;
    logic        req_rw = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [2:0]  req_len = 3'd0;
    logic [31:0] wr_data = 32'h0;
    logic        busy, done, error, ee_start, ee_rw;
    logic [31:0] rd_data;
    logic [7:0]  ee_address, ee_data_in;
    logic [7:0]  ee_data_out;
    logic        ee_done;

    eeprom_burst_sequencer #(
        .SYS_FREQ    (c_SYS_FREQ),
        .MAX_LEN     (c_MAX_LEN),
        .TWR_US      (c_TWR_US),
        .TIMEOUT_CYC (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_start   (req_start),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rd_data     (rd_data),
        .ee_start    (ee_start),
        .ee_rw       (ee_rw),
        .ee_address  (ee_address),
        .ee_data_in  (ee_data_in),
        .ee_data_out (ee_data_out),
        .ee_done     (ee_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic rw; logic [7:0] data; } ee_exp_t;
    // ref_kind: 1 = last ee_done, 2 = last accepted req_start, 3 = last ee_start
    typedef struct { logic err; logic [31:0] rd; int ref_kind; int gap; } done_exp_t;

    ee_exp_t   exp_ee[$];
    done_exp_t exp_done[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    int last_done_cyc = 0;
    int last_start_cyc = 0;
    int last_wr_start = -1;

    logic       model_mute = 1'b0;
    logic       corrupt_en = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;
    logic [7:0] mem [256];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pops expectations whenever the DUT presents ee_start or done.
    always @(negedge clk) begin
        ee_exp_t   e;
        done_exp_t d;
        int        ref_c;
        if (rst) begin
            last_wr_start = -1;
        end else begin
            if (req_start && !busy) last_req_cyc = cyc;
            if (ee_done) last_done_cyc = cyc;
            if (ee_start) begin
                last_start_cyc = cyc;
                if (exp_ee.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ee_start: addr %h rw %0d with nothing pending", ee_address, ee_rw);
                end else begin
                    e = exp_ee.pop_front();
                    chk("ee_address", 32'(ee_address), 32'(e.addr));
                    chk("ee_rw", 32'(ee_rw), 32'(e.rw));
                    chk("ee_data_in", 32'(ee_data_in), 32'(e.data));
                end
                if (!ee_rw) begin
                    if (last_wr_start >= 0) begin
                        total++;
                        if (cyc - last_wr_start < c_TWR) begin
                            bad++;
                            $display("FAIL write_spacing: got %0d cycles required >= %0d", cyc - last_wr_start, c_TWR);
                        end
                    end
                    last_wr_start = cyc;
                end
            end
            if (done) begin
                last_wr_start = -1;
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: error %0d rd_data %h", error, rd_data);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_error", 32'(error), 32'(d.err));
                    chk("done_rd_data", rd_data, d.rd);
                    ref_c = (d.ref_kind == 1) ? last_done_cyc :
                            (d.ref_kind == 2) ? last_req_cyc : last_start_cyc;
                    chk("done_latency", 32'(cyc - ref_c), 32'(d.gap));
                end
            end
        end
    end

    // Single-byte EEPROM model: ack 3 cycles after each start.
    initial begin
        logic [7:0] a;
        logic [7:0] dat;
        logic       rw;
        ee_done = 1'b0;
        ee_data_out = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        forever begin
            @(negedge clk);
            if (ee_start && !rst && !model_mute) begin
                a = ee_address;
                rw = ee_rw;
                dat = ee_data_in;
                repeat (3) @(posedge clk);
                #1;
                if (rw) begin
                    ee_data_out = (corrupt_en && a == corrupt_addr) ? ~mem[a] : mem[a];
                end else begin
                    mem[a] = dat;
                end
                ee_done = 1'b1;
                @(posedge clk);
                #1 ee_done = 1'b0;
            end
        end
    end

    task automatic push_ee(input logic [7:0] addr, input logic rw, input logic [7:0] data);
        ee_exp_t e;
        e.addr = addr;
        e.rw = rw;
        e.data = data;
        exp_ee.push_back(e);
    endtask

    task automatic push_done(input logic err, input logic [31:0] rd, input int kind, input int gap);
        done_exp_t d;
        d.err = err;
        d.rd = rd;
        d.ref_kind = kind;
        d.gap = gap;
        exp_done.push_back(d);
    endtask

    task automatic send(input logic rw, input logic [7:0] addr, input logic [2:0] len, input logic [31:0] data);
        @(posedge clk);
        #1;
        req_rw = rw;
        req_addr = addr;
        req_len = len;
        wr_data = data;
        req_start = 1'b1;
        @(posedge clk);
        #1 req_start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || exp_ee.size() != 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        if (exp_done.size() != 0 || exp_ee.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: pending ee=%0d done=%0d after %0d cycles", name, exp_ee.size(), exp_done.size(), n);
            exp_ee.delete();
            exp_done.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_ee_start"}, 32'(ee_start), 32'd0);
        chk({tag, "_ee_rw"}, 32'(ee_rw), 32'd0);
        chk({tag, "_ee_address"}, 32'(ee_address), 32'd0);
        chk({tag, "_ee_data_in"}, 32'(ee_data_in), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Write burst 0x01, len 3 -> FF, 80, 3C
        push_ee(8'h01, 1'b0, 8'hFF);
`ifdef EEPROM_VERIFY_EN
        push_ee(8'h01, 1'b1, 8'hFF);
        push_ee(8'h02, 1'b0, 8'h80);
        push_ee(8'h02, 1'b1, 8'h80);
        push_ee(8'h03, 1'b0, 8'h3C);
        push_ee(8'h03, 1'b1, 8'h3C);
        push_done(1'b0, 32'h0, 1, 2);
`else
        push_ee(8'h02, 1'b0, 8'h80);
        push_ee(8'h03, 1'b0, 8'h3C);
        push_done(1'b0, 32'h0, 1, c_TWR + 3);
`endif
        send(1'b0, 8'h01, 3'd3, 32'h003C80FF);
        wait_drain("write_burst", 1000);

        // Read back the same three bytes
        push_ee(8'h01, 1'b1, 8'h00);
        push_ee(8'h02, 1'b1, 8'h00);
        push_ee(8'h03, 1'b1, 8'h00);
        push_done(1'b0, 32'h003C80FF, 1, 2);
        send(1'b1, 8'h01, 3'd3, 32'h0);
        wait_drain("read_burst", 500);

        // Address wrap 0xFE..0x01
        push_ee(8'hFE, 1'b1, 8'h00);
        push_ee(8'hFF, 1'b1, 8'h00);
        push_ee(8'h00, 1'b1, 8'h00);
        push_ee(8'h01, 1'b1, 8'h00);
        push_done(1'b0, 32'hFF332211, 1, 2);
        send(1'b1, 8'hFE, 3'd4, 32'h0);
        wait_drain("wrap_read", 500);

        // Length errors: no ee_start, done+error two cycles after the request
        push_done(1'b1, 32'h0, 2, 2);
        send(1'b0, 8'h40, 3'd0, 32'h12345678);
        wait_drain("len0", 100);
        push_done(1'b1, 32'h0, 2, 2);
        send(1'b0, 8'h40, 3'd5, 32'h12345678);
        wait_drain("len5", 100);
        chk("len5_error_held", 32'(error), 32'd1);

        // Timeout with a silent EEPROM; a request while busy must be dropped
        model_mute = 1'b1;
        push_ee(8'h10, 1'b1, 8'h00);
        push_done(1'b1, 32'h0, 3, c_TIMEOUT + 3);
        send(1'b1, 8'h10, 3'd2, 32'h0);
        repeat (20) @(posedge clk);
        send(1'b0, 8'h50, 3'd1, 32'h000000EE);
        wait_drain("timeout", 400);
        chk("timeout_error_held", 32'(error), 32'd1);
        model_mute = 1'b0;

        // Reset while the second write byte is in flight
        push_ee(8'h20, 1'b0, 8'hAA);
`ifdef EEPROM_VERIFY_EN
        push_ee(8'h20, 1'b1, 8'hAA);
`endif
        push_ee(8'h21, 1'b0, 8'h55);
        send(1'b0, 8'h20, 3'd3, 32'h009955AA);
        n = 0;
        while (exp_ee.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_ee.size() != 0) begin
            total++;
            bad++;
            $display("FAIL mid_reset_wait: %0d ee_start still pending", exp_ee.size());
            exp_ee.delete();
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        repeat (15) @(posedge clk);

        push_ee(8'h02, 1'b1, 8'h00);
        push_ee(8'h03, 1'b1, 8'h00);
        push_done(1'b0, 32'h00003C80, 1, 2);
        send(1'b1, 8'h02, 3'd2, 32'h0);
        wait_drain("after_reset_read", 500);

`ifdef EEPROM_VERIFY_EN
        // Verify readback of byte 1 is corrupted: abort after two writes
        corrupt_en = 1'b1;
        corrupt_addr = 8'h31;
        push_ee(8'h30, 1'b0, 8'h11);
        push_ee(8'h30, 1'b1, 8'h11);
        push_ee(8'h31, 1'b0, 8'h22);
        push_ee(8'h31, 1'b1, 8'h22);
        push_done(1'b1, 32'h0, 1, 2);
        send(1'b0, 8'h30, 3'd3, 32'h00332211);
        wait_drain("verify_corrupt", 1000);
        corrupt_en = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeprom_burst_sequencer.md
Name: eeprom_burst_sequencer

Overview:
- Sequences multi-byte EEPROM transfers on top of the single-byte i2c_eeprom controller, which uses a start/done handshake per byte.
- Accepts one burst request of 1..MAX_LEN bytes and issues consecutive byte operations at incrementing addresses.
- Inserts the EEPROM internal write-cycle delay (tWR) after every write byte.
- Packs read bytes into one word and reports done, error and timeout.
- Sits between the demo/application FSM (colour save/recall) and i2c_eeprom, replacing hand-coded byte_counter sequencing.

Parameters:
- SYS_FREQ, 12_090_000, system clock frequency in Hz.
- MAX_LEN, 4, maximum burst length in bytes.
- TWR_US, 5000, write-cycle wait after each written byte, in µs. Benches override this with a small value.
- TIMEOUT_CYC, 65535, maximum clk cycles to wait for ee_done before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_start  in  1  request strobe; sampled only when busy=0.
- req_rw  in  1  0 = write, 1 = read.
- req_addr  in  8  first EEPROM address.
- req_len  in  3  byte count; valid range 1..MAX_LEN.
- wr_data  in  8*MAX_LEN  write bytes; byte i is at [8i+7:8i].
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; held until the next accepted request.
- rd_data  out  8*MAX_LEN  read bytes, same packing as wr_data.
- ee_start  out  1  one-cycle start pulse to i2c_eeprom.
- ee_rw  out  1  to i2c_eeprom rw.
- ee_address  out  8  to i2c_eeprom address.
- ee_data_in  out  8  to i2c_eeprom data_in.
- ee_data_out  in  8  from i2c_eeprom data_out.
- ee_done  in  1  from i2c_eeprom done.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. Internal counters and latches are cleared.
- States: IDLE, ISSUE, WAIT_DONE, TWR_WAIT, FINISH (plus VFY_ISSUE and VFY_WAIT with the optional feature).
- IDLE:
  - On req_start=1, latch rw, addr, len and wr_data; clear error and rd_data; set busy=1.
  - If len=0 or len>MAX_LEN, go to FINISH with error=1. No ee_start is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - ee_start=1 for exactly one cycle.
  - ee_address, ee_rw and ee_data_in = current byte. All three stay stable until the next ISSUE.
  - Load the timeout counter, then go to WAIT_DONE.
- WAIT_DONE:
  - On ee_done, a read stores ee_data_out into rd_data byte index idx.
  - A write goes to TWR_WAIT with the tWR counter loaded to SYS_FREQ/1000*TWR_US/1000 cycles.
  - A read then increments idx and addr: ISSUE if idx+1<len, else FINISH.
  - If the counter expires with no ee_done, set error=1 and go to FINISH. Remaining bytes are not attempted.
- TWR_WAIT: on counter reaching 0, increment idx and addr: ISSUE if bytes remain, else FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - Read: done asserts exactly 2 cycles after the last ee_done.
  - Write: done asserts exactly 2 cycles after tWR expiry of the last byte.
  - Length error: done asserts 2 cycles after req_start.
- Address arithmetic is 8-bit; 0xFF wraps to 0x00 silently.
- Unread rd_data bytes (index ≥ len) stay 0.
- ee_done outside WAIT_DONE/VFY_WAIT is ignored.
- req_start while busy=1 is ignored; nothing is queued.
- Reset mid-burst aborts immediately: no done pulse, ee_start forced low. Any in-flight i2c transaction is the controller's responsibility.

Optional Feature:
- Macro: EEPROM_VERIFY_EN.
- When defined, after each write's TWR_WAIT the FSM goes to VFY_ISSUE. It issues a read (ee_rw=1) of the same address, then waits in VFY_WAIT with the same timeout.
- If ee_data_out differs from the written byte, set error=1 and go to FINISH immediately.
- If it matches, advance as in TWR_WAIT.
- When undefined, the verify states, comparator and their logic are absent. Error sources are then only length and timeout.

Decomposition:
- Package eeprom_seq_pkg holds:
  - state encoding constants;
  - the TWR cycle-count calculation as a constant function of SYS_FREQ and TWR_US;
  - the counter width (clog2 of max(TWR cycles, TIMEOUT_CYC)+1).
- One sub-module, eeprom_wait_timer: a loadable down-counter with a load/value input and an expired output, shared between timeout and tWR waits.

Test Plan:
- Write burst: addr=0x01, len=3, wr_data=0x0000_3C_80_FF with a bench EEPROM model.
  - Exactly 3 ee_start pulses, at addresses 0x01/0x02/0x03 with data 0xFF/0x80/0x3C.
  - Each pulse separated by ≥ TWR cycles.
  - done with error=0.
- Read burst: addr=0x01, len=3, model returns 0xFF,0x80,0x3C.
  - rd_data=0x0000_3C_80_FF.
  - done exactly 2 cycles after the 3rd ee_done.
- Wrap: addr=0xFE, len=4 read → ee_address sequence 0xFE, 0xFF, 0x00, 0x01.
- Length error: len=0 and len=5.
  - No ee_start.
  - done+error exactly 2 cycles after req_start.
- Timeout and busy: model never asserts ee_done, with TIMEOUT_CYC=100.
  - error=1 and done at cycle ~101 after ee_start.
  - A req_start pulsed during the busy period is ignored.
- Reset mid-burst (rst high during the 2nd byte):
  - all outputs 0 the next cycle, no done;
  - the next request completes normally.
  - With EEPROM_VERIFY_EN, the model corrupts byte 1 → error=1 and only 2 write ee_starts are seen.
